uart_rx_fsm: RTL

Frame-sequencing controller for the UART receiver.
- Detects the start-bit falling edge on RX_IN.
- Enables and steps the shared edge_bit_counter through start, data, optional parity and stop bits.
- Issues sample, shift and check strobes to the data sampler, deserializer and start/parity/stop checkers.
- Raises data_valid for one cycle on an error-free frame.
- Sits between the RX line input and the rest of the UART_RX datapath; owns no data itself.

---
 rtl/uart_rx_pkg.sv | 29 ++
 rtl/uart_rx_fsm_if.sv | 48 ++++
 rtl/uart_rx_fsm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared types and constants for the UART receiver frame sequencer.
package uart_rx_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    // Bit indices reported by edge_bit_counter.
    localparam logic [3:0] START_BIT  = 4'd0;
    localparam logic [3:0] PARITY_BIT = 4'(DATA_WIDTH_DEF + 1);

    // Supported oversampling ratios.
    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_e;

    // The shared counter runs only while a bit of the frame is being timed.
    function automatic logic counter_active(input rx_state_e s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// uart_rx_fsm_if: line, counter, checker and strobe signals of the RX sequencer.
// With UART_RX_ERR_FLAGS_EN defined it also carries par_err_flag / stp_err_flag.
interface uart_rx_fsm_if #(
    parameter int Prescale_width = 6
);
    logic                      RX_IN;
    logic                      PAR_EN;
    logic [Prescale_width-1:0] Prescale;
    logic [Prescale_width-1:0] edge_cnt;
    logic [3:0]                bit_cnt;
    logic                      strt_glitch;
    logic                      par_err;
    logic                      stp_err;
    logic                      enable;
    logic                      dat_samp_en;
    logic                      deser_en;
    logic                      strt_chk_en;
    logic                      par_chk_en;
    logic                      stp_chk_en;
    logic                      data_valid;
`ifdef UART_RX_ERR_FLAGS_EN
    logic                      par_err_flag;
    logic                      stp_err_flag;
`endif

    // Sequencer side.
    modport slave (
        input  RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt,
        input  strt_glitch, par_err, stp_err,
        output enable, dat_samp_en, deser_en, strt_chk_en,
        output par_chk_en, stp_chk_en, data_valid
`ifdef UART_RX_ERR_FLAGS_EN
        , output par_err_flag, stp_err_flag
`endif
    );

    // Datapath / environment side.
    modport master (
        output RX_IN, PAR_EN, Prescale, edge_cnt, bit_cnt,
        output strt_glitch, par_err, stp_err,
        input  enable, dat_samp_en, deser_en, strt_chk_en,
        input  par_chk_en, stp_chk_en, data_valid
`ifdef UART_RX_ERR_FLAGS_EN
        , input par_err_flag, stp_err_flag
`endif
    );

endinterface

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame sequencer. Detects the start edge, steps the
// shared edge_bit_counter through start/data/parity/stop and issues the check
// and shift strobes; data_valid pulses once for an error-free frame.
// Optional macro UART_RX_ERR_FLAGS_EN adds sticky parity/stop error flags.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int Prescale_width = 6,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         reset,
    uart_rx_fsm_if.slave bus
);

    rx_state_e                 state_q, state_d;
    logic                      par_en_q, par_en_d;
    logic [Prescale_width-1:0] prescale_q, prescale_d;
    logic                      frame_err_q, frame_err_d;
`ifdef UART_RX_ERR_FLAGS_EN
    logic                      par_flag_q, par_flag_d;
    logic                      stp_flag_q, stp_flag_d;
`endif

    logic [Prescale_width-1:0] last_edge_s;
    logic [Prescale_width-1:0] strobe_edge_s;
    logic                      at_last_s;
    logic                      at_strobe_s;
    logic                      last_data_bit_s;
    logic                      enable_s;
    logic                      strt_s;
    logic                      deser_s;
    logic                      par_s;
    logic                      stp_s;

    // Bit timing is taken from the Prescale latched at frame start.
    assign last_edge_s     = prescale_q - Prescale_width'(1);
    assign strobe_edge_s   = prescale_q - Prescale_width'(2);
    assign at_last_s       = (bus.edge_cnt == last_edge_s);
    assign at_strobe_s     = (bus.edge_cnt == strobe_edge_s);
    assign last_data_bit_s = (bus.bit_cnt == 4'(DATA_WIDTH));

    // Next-state and frame-configuration logic.
    always_comb begin
        state_d     = state_q;
        par_en_d    = par_en_q;
        prescale_d  = prescale_q;
        frame_err_d = frame_err_q;
`ifdef UART_RX_ERR_FLAGS_EN
        par_flag_d  = par_flag_q;
        stp_flag_d  = stp_flag_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (!bus.RX_IN) begin
                    // Every frame start snapshots its configuration and clears errors.
                    state_d     = START;
                    par_en_d    = bus.PAR_EN;
                    prescale_d  = bus.Prescale;
                    frame_err_d = 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
                    par_flag_d  = 1'b0;
                    stp_flag_d  = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (at_last_s) begin
                    state_d = bus.strt_glitch ? IDLE : DATA;
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (at_last_s && last_data_bit_s) begin
                    state_d = par_en_q ? PARITY : STOP;
                end else begin
                    state_d = DATA;
                end
            end
            PARITY: begin
                if (at_last_s) begin
                    state_d     = STOP;
                    frame_err_d = bus.par_err;
`ifdef UART_RX_ERR_FLAGS_EN
                    par_flag_d  = par_flag_q | bus.par_err;
`endif
                end else begin
                    state_d = PARITY;
                end
            end
            STOP: begin
                if (at_last_s) begin
                    state_d    = (!bus.stp_err && !frame_err_q) ? DONE : IDLE;
`ifdef UART_RX_ERR_FLAGS_EN
                    stp_flag_d = stp_flag_q | bus.stp_err;
`endif
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched frame configuration registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            par_en_q    <= 1'b0;
            prescale_q  <= '0;
            frame_err_q <= 1'b0;
`ifdef UART_RX_ERR_FLAGS_EN
            par_flag_q  <= 1'b0;
            stp_flag_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            par_en_q    <= par_en_d;
            prescale_q  <= prescale_d;
            frame_err_q <= frame_err_d;
`ifdef UART_RX_ERR_FLAGS_EN
            par_flag_q  <= par_flag_d;
            stp_flag_q  <= stp_flag_d;
`endif
        end
    end

    // Strobe decode: one pulse per bit, one edge before the bit's last edge.
    always_comb begin
        enable_s = counter_active(state_q);
        strt_s   = 1'b0;
        deser_s  = 1'b0;
        par_s    = 1'b0;
        stp_s    = 1'b0;
        case (state_q)
            START:   strt_s  = at_strobe_s;
            DATA:    deser_s = at_strobe_s;
            PARITY:  par_s   = at_strobe_s;
            STOP:    stp_s   = at_strobe_s;
            default: begin
                strt_s = 1'b0;
            end
        endcase
    end

    assign bus.enable      = enable_s;
    assign bus.dat_samp_en = enable_s;
    assign bus.deser_en    = deser_s;
    assign bus.strt_chk_en = strt_s;
    assign bus.par_chk_en  = par_s;
    assign bus.stp_chk_en  = stp_s;
    assign bus.data_valid  = (state_q == DONE);
`ifdef UART_RX_ERR_FLAGS_EN
    assign bus.par_err_flag = par_flag_q;
    assign bus.stp_err_flag = stp_flag_q;
`endif

endmodule
